led8_ring_monitor: RTL and testbench

Receive-side checker for the 8-bit rotating one-hot LED ring bus driven by the led8 pipe generator. Each qualified sample is checked for one-hot validity and for a correct single-step rotation (bit i moves to bit i+1, bit 7 wraps to bit 0). The block reports the current position, locks after a run of good steps, counts full laps and flags rotation errors. It sits beside the generator in the frequency lab and gives the bench and on-board logic a self-check of the ring.

---
 rtl/led8_ring_monitor.sv | 146 ++++++++++++++
 tb/tb_led8_ring_monitor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led8_ring_monitor.sv
`default_nettype none
// ============================================================================
// Module      : led8_ring_monitor
// Description : Receive-side checker for the 8-bit rotating one-hot LED ring.
//               Tracks position, locks on a run of good steps, counts laps and
//               flags rotation errors while locked.
// Revision    : 1.0 - initial release
// ============================================================================
module led8_ring_monitor #(
  parameter int LOCK_CNT = 4,
  parameter int LAP_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       diode,
  input  logic             sample_en,
  input  logic             clear_err,
  output logic [2:0]       pos,
  output logic             onehot_ok,
  output logic             locked,
  output logic             step_err,
  output logic             err_sticky,
  output logic             lap_pulse,
  output logic [LAP_W-1:0] lap_cnt
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [3:0] c_LOCK_LAST = 4'(LOCK_CNT - 1);

  state_t           r_state;
  logic [3:0]       r_good;
  logic [7:0]       r_prev;
  logic             r_have_prev;
  logic [2:0]       r_pos;
  logic             r_onehot_ok;
  logic             r_locked;
  logic             r_step_err;
  logic             r_err_sticky;
  logic             r_lap_pulse;
  logic [LAP_W-1:0] r_lap_cnt;

  logic             w_onehot;
  logic [7:0]       w_rot;
  logic             w_match;
  logic [2:0]       w_pos;
  logic             w_err;
  logic             w_lap_max;

  assign w_onehot  = (diode != 8'h00) && ((diode & (diode - 8'd1)) == 8'h00);
  assign w_rot     = {r_prev[6:0], r_prev[7]};
  assign w_match   = r_have_prev & w_onehot & (diode == w_rot);
  assign w_err     = sample_en & (r_state == ST_LOCKED) & ~w_match;
  assign w_lap_max = &r_lap_cnt;

  always_comb begin
    w_pos = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (diode[i]) w_pos = 3'(i);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_SEARCH;
      r_good       <= 4'd0;
      r_prev       <= 8'h00;
      r_have_prev  <= 1'b0;
      r_pos        <= 3'd0;
      r_onehot_ok  <= 1'b0;
      r_locked     <= 1'b0;
      r_step_err   <= 1'b0;
      r_err_sticky <= 1'b0;
      r_lap_pulse  <= 1'b0;
      r_lap_cnt    <= '0;
    end else begin
      r_step_err  <= 1'b0;
      r_lap_pulse <= 1'b0;
      if (sample_en) begin
        r_prev      <= diode;
        r_have_prev <= 1'b1;
        r_onehot_ok <= w_onehot;
        if (w_onehot) r_pos <= w_pos;
        case (r_state)
          ST_SEARCH: begin
            if (w_match) begin
              if (r_good == c_LOCK_LAST) begin
                r_state  <= ST_LOCKED;
                r_locked <= 1'b1;
                r_good   <= 4'd0;
              end else begin
                r_good <= r_good + 4'd1;
              end
            end else begin
              r_good <= 4'd0;
            end
          end
          ST_LOCKED: begin
            if (w_match) begin
              if (diode == 8'h01) begin
                r_lap_pulse <= 1'b1;
                if (!w_lap_max) r_lap_cnt <= r_lap_cnt + LAP_W'(1);
              end
            end else begin
              r_step_err   <= 1'b1;
              r_err_sticky <= 1'b1;
              r_state      <= ST_FAULT;
              r_locked     <= 1'b0;
            end
          end
          ST_FAULT: begin
            // The first one-hot sample restarts the search from that pattern.
            if (w_onehot) begin
              r_state <= ST_SEARCH;
              r_good  <= 4'd0;
            end
          end
          default: begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
            r_good   <= 4'd0;
          end
        endcase
      end
      // Clear acts regardless of sample_en; a same-cycle error keeps the flag set.
      if (clear_err) begin
        r_lap_cnt <= '0;
        if (!w_err) r_err_sticky <= 1'b0;
      end
    end
  end

  assign pos        = r_pos;
  assign onehot_ok  = r_onehot_ok;
  assign locked     = r_locked;
  assign step_err   = r_step_err;
  assign err_sticky = r_err_sticky;
  assign lap_pulse  = r_lap_pulse;
  assign lap_cnt    = r_lap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_led8_ring_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_led8_ring_monitor
// Description : Directed and randomized bench for led8_ring_monitor with a
//               behavioural ring model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led8_ring_monitor;
  localparam int LOCK_CNT = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  diode = 8'h00;
  logic        sample_en = 1'b0;
  logic        clear_err = 1'b0;

  logic [2:0]  pos, pos_b;
  logic        onehot_ok, onehot_ok_b;
  logic        locked, locked_b;
  logic        step_err, step_err_b;
  logic        err_sticky, err_sticky_b;
  logic        lap_pulse, lap_pulse_b;
  logic [15:0] lap_cnt;
  logic [1:0]  lap_cnt_b;

  always #5 clock = ~clock;

  led8_ring_monitor #(.LOCK_CNT(LOCK_CNT), .LAP_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .diode(diode), .sample_en(sample_en),
    .clear_err(clear_err), .pos(pos), .onehot_ok(onehot_ok), .locked(locked),
    .step_err(step_err), .err_sticky(err_sticky), .lap_pulse(lap_pulse),
    .lap_cnt(lap_cnt)
  );

  led8_ring_monitor #(.LOCK_CNT(LOCK_CNT), .LAP_W(2)) dut_w2 (
    .clock(clock), .reset_n(reset_n), .diode(diode), .sample_en(sample_en),
    .clear_err(clear_err), .pos(pos_b), .onehot_ok(onehot_ok_b), .locked(locked_b),
    .step_err(step_err_b), .err_sticky(err_sticky_b), .lap_pulse(lap_pulse_b),
    .lap_cnt(lap_cnt_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: mode 0 = searching, 1 = locked, 2 = faulted
  int         m_mode;
  int         m_streak;
  logic [7:0] m_prev;
  bit         m_have;
  int         m_laps16, m_laps2;
  bit         m_sticky;
  int         e_pos;
  bit         e_onehot, e_step, e_lap;
  logic [7:0] cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v);
    return 8'((int'(v) * 2) % 256 + int'(v) / 128);
  endfunction

  function automatic logic [7:0] rotr(input logic [7:0] v);
    return 8'(int'(v) / 2 + (int'(v) % 2) * 128);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_streak = 0; m_prev = 8'h00; m_have = 0;
    m_laps16 = 0; m_laps2 = 0; m_sticky = 0;
    e_pos = 0; e_onehot = 0; e_step = 0; e_lap = 0;
  endtask

  task automatic model_step();
    bit oh, good, err;
    e_step = 0; e_lap = 0; err = 0;
    if (sample_en) begin
      oh   = ($countones(diode) == 1);
      good = m_have && oh && (diode == rotl(m_prev));
      e_onehot = oh;
      if (oh) for (int i = 0; i < 8; i++) if (diode == 8'(1 << i)) e_pos = i;
      if (m_mode == 0) begin
        if (good) begin
          m_streak++;
          if (m_streak == LOCK_CNT) begin m_mode = 1; m_streak = 0; end
        end else m_streak = 0;
      end else if (m_mode == 1) begin
        if (good) begin
          if (diode == 8'h01) begin
            e_lap = 1;
            m_laps16 = (m_laps16 < 65535) ? m_laps16 + 1 : 65535;
            m_laps2  = (m_laps2 < 3) ? m_laps2 + 1 : 3;
          end
        end else begin
          e_step = 1; err = 1; m_sticky = 1; m_mode = 2;
        end
      end else begin
        if (oh) begin m_mode = 1 - 1; m_streak = 0; end
      end
      m_prev = diode; m_have = 1;
    end
    if (clear_err) begin
      m_laps16 = 0; m_laps2 = 0;
      if (!err) m_sticky = 0;
    end
  endtask

  task automatic check_all();
    check("pos",        32'(pos),        32'(e_pos));
    check("onehot_ok",  32'(onehot_ok),  32'(e_onehot));
    check("locked",     32'(locked),     32'(m_mode == 1));
    check("step_err",   32'(step_err),   32'(e_step));
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    check("lap_pulse",  32'(lap_pulse),  32'(e_lap));
    check("lap_cnt",    32'(lap_cnt),    32'(m_laps16));
    check("lap_cnt_w2", 32'(lap_cnt_b),  32'(m_laps2));
  endtask

  task automatic do_cycle(input logic [7:0] d, input logic en, input logic clr);
    @(negedge clock);
    diode = d; sample_en = en; clear_err = clr;
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic rot_run(input int n);
    for (int k = 0; k < n; k++) begin
      cur = rotl(cur);
      do_cycle(cur, 1'b1, 1'b0);
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    sample_en = 1'b0; clear_err = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_lapcnt", 32'(lap_cnt), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int r;
    logic [7:0] nxt;
    logic en, clr;

    apply_reset();

    // Lock and track
    cur = 8'h01; do_cycle(cur, 1'b1, 1'b0);
    rot_run(3);
    check("pre_lock", 32'(locked), 32'd0);
    rot_run(1);
    check("locked_after_10", 32'(locked), 32'd1);
    check("pos_after_10", 32'(pos), 32'd4);

    // Laps
    rot_run(3);
    rot_run(1);
    check("lap_pulse_1", 32'(lap_pulse), 32'd1);
    check("lap_cnt_1", 32'(lap_cnt), 32'd1);
    rot_run(8);
    check("lap_cnt_2", 32'(lap_cnt), 32'd2);

    // Non-one-hot while locked, then fault, then relock
    do_cycle(8'h00, 1'b1, 1'b0);
    check("err_pulse_zero", 32'(step_err), 32'd1);
    check("err_sticky_zero", 32'(err_sticky), 32'd1);
    check("pos_hold_zero", 32'(pos), 32'd0);
    do_cycle(8'h03, 1'b1, 1'b0);
    cur = 8'h04; do_cycle(cur, 1'b1, 1'b0);
    rot_run(4);
    check("relock", 32'(locked), 32'd1);

    // Held pattern
    rot_run(5);
    do_cycle(cur, 1'b1, 1'b0);
    check("err_hold", 32'(step_err), 32'd1);
    do_cycle(cur, 1'b1, 1'b0);
    rot_run(4);
    check("relock_hold", 32'(locked), 32'd1);

    // Reversed step
    rot_run(4);
    cur = rotr(cur); do_cycle(cur, 1'b1, 1'b0);
    check("err_reverse", 32'(step_err), 32'd1);
    rot_run(5);
    check("relock_rev", 32'(locked), 32'd1);

    // Qualifier: garbage while sample_en is low
    for (int k = 0; k < 20; k++) do_cycle(8'($urandom), 1'b0, 1'b0);
    rot_run(1);
    check("resume_locked", 32'(locked), 32'd1);
    check("resume_noerr", 32'(step_err), 32'd0);

    // Clear interplay
    do_cycle(8'h00, 1'b1, 1'b1);
    check("clr_vs_err", 32'(err_sticky), 32'd1);
    do_cycle(8'h5a, 1'b0, 1'b1);
    check("clr_sticky", 32'(err_sticky), 32'd0);
    check("clr_lapcnt", 32'(lap_cnt), 32'd0);

    // Saturation of the narrow counter
    cur = 8'h01; do_cycle(cur, 1'b1, 1'b0);
    rot_run(4);
    rot_run(40);
    check("sat_w2", 32'(lap_cnt_b), 32'd3);
    check("laps_w16", 32'(lap_cnt), 32'd5);
    rot_run(3);
    cur = 8'h01; do_cycle(cur, 1'b1, 1'b1);
    check("lap_clr_pulse", 32'(lap_pulse), 32'd1);
    check("lap_clr_cnt", 32'(lap_cnt), 32'd0);

    // Asynchronous reset mid-operation
    rot_run(8);
    check("pre_reset_lap", 32'(lap_cnt), 32'd1);
    apply_reset();
    cur = 8'h01; do_cycle(cur, 1'b1, 1'b0);
    rot_run(LOCK_CNT - 1);
    check("post_rst_nolock", 32'(locked), 32'd0);
    rot_run(1);
    check("post_rst_lock", 32'(locked), 32'd1);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r   = $urandom_range(0, 99);
      en  = ($urandom_range(0, 99) < 85);
      clr = ($urandom_range(0, 99) < 3);
      if (r < 70)      nxt = rotl(cur);
      else if (r < 78) nxt = cur;
      else if (r < 86) nxt = rotr(cur);
      else if (r < 93) nxt = 8'($urandom);
      else             nxt = 8'(1 << $urandom_range(0, 7));
      if (en) cur = nxt;
      do_cycle(nxt, en, clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
